vga_scan_out: RTL and testbench

VGA_SCAN_OUT -- requirements
Module: vga_scan_out

---
 rtl/vga_scan_out.sv | 113 +++++++++++
 tb/tb_vga_scan_out.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_out.sv
// VGA raster generator: pixel-rate counters, sync/blank timing and a registered colour path to the DAC.
// The pixel rate is half of clk; every timing output lags the coordinates by one pixel.
module vga_scan_out #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [7:0]  redIn,
    input  logic [7:0]  greenIn,
    input  logic [7:0]  blueIn,
    output logic [10:0] pixelX,
    output logic [10:0] pixelY,
    output logic        startOfFrame,
    output logic [7:0]  oVGA_R,
    output logic [7:0]  oVGA_G,
    output logic [7:0]  oVGA_B,
    output logic        oVGA_HS,
    output logic        oVGA_VS,
    output logic        oVGA_BLANK_N,
    output logic        oVGA_SYNC_N,
    output logic        oVGA_CLK
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic          pix_en;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_last_c;
    logic          v_last_c;
    logic          active_c;
    logic          hs_c;
    logic          vs_c;

    // Decode of the current (pre-increment) raster position
    assign h_last_c = (h_cnt == H_LAST);
    assign v_last_c = (v_cnt == V_LAST);
    assign active_c = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
    assign hs_c     = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
    assign vs_c     = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);

    assign pixelX      = 11'(h_cnt);
    assign pixelY      = 11'(v_cnt);
    assign oVGA_SYNC_N = 1'b1;
    assign oVGA_CLK    = pix_en;

    // Pixel enable: high every other clk, first tick on the second edge after reset
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pix_en <= 1'b0;
        end else begin
            pix_en <= ~pix_en;
        end
    end

    // Raster counters
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_last_c) begin
                h_cnt <= '0;
                v_cnt <= v_last_c ? '0 : v_cnt + VW'(1);
            end else begin
                h_cnt <= h_cnt + HW'(1);
            end
        end
    end

    // DAC-side registers; startOfFrame falls on the clk after its tick
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            oVGA_R       <= 8'd0;
            oVGA_G       <= 8'd0;
            oVGA_B       <= 8'd0;
            oVGA_BLANK_N <= 1'b0;
            oVGA_HS      <= 1'b1;
            oVGA_VS      <= 1'b1;
            startOfFrame <= 1'b0;
        end else begin
            startOfFrame <= 1'b0;
            if (pix_en) begin
                oVGA_R       <= active_c ? redIn   : 8'd0;
                oVGA_G       <= active_c ? greenIn : 8'd0;
                oVGA_B       <= active_c ? blueIn  : 8'd0;
                oVGA_BLANK_N <= active_c;
                oVGA_HS      <= ~hs_c;
                oVGA_VS      <= ~vs_c;
                startOfFrame <= h_last_c && v_last_c;
            end
        end
    end

endmodule

// File: tb/tb_vga_scan_out.sv
// Bench for vga_scan_out on a reduced raster; expected outputs come from an edge-count model of the timing.
module tb_vga_scan_out;
    localparam int unsigned HA = 20, HF = 3, HSW = 5, HB = 6;
    localparam int unsigned VA = 12, VF = 2, VSW = 2, VB = 3;
    localparam int unsigned HT = HA + HF + HSW + HB;
    localparam int unsigned VT = VA + VF + VSW + VB;
    localparam int unsigned FRAME = HT * VT;

    logic        clk;
    logic        resetN;
    logic [7:0]  redIn, greenIn, blueIn;
    logic [10:0] pixelX, pixelY;
    logic        startOfFrame;
    logic [7:0]  oVGA_R, oVGA_G, oVGA_B;
    logic        oVGA_HS, oVGA_VS, oVGA_BLANK_N, oVGA_SYNC_N, oVGA_CLK;

    logic [7:0]  drv_r, drv_g, drv_b, mux_r;
    int unsigned mode;
    int unsigned n_assert, n_fail;
    int unsigned k;
    int unsigned exp_x, exp_y, exp_r, exp_g, exp_b, exp_blank, exp_hs, exp_vs, exp_sof, exp_clk;
    int unsigned hs_run, hs_gap, vs_run, sof_gap, sof_count;
    bit          hs_prev, hs_seen, sof_seen, found;

    vga_scan_out #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB)
    ) dut (
        .clk(clk), .resetN(resetN),
        .redIn(redIn), .greenIn(greenIn), .blueIn(blueIn),
        .pixelX(pixelX), .pixelY(pixelY), .startOfFrame(startOfFrame),
        .oVGA_R(oVGA_R), .oVGA_G(oVGA_G), .oVGA_B(oVGA_B),
        .oVGA_HS(oVGA_HS), .oVGA_VS(oVGA_VS), .oVGA_BLANK_N(oVGA_BLANK_N),
        .oVGA_SYNC_N(oVGA_SYNC_N), .oVGA_CLK(oVGA_CLK)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the object mux: one-clk registered colour derived from pixelX
    always @(posedge clk) mux_r <= pixelX[7:0];
    assign redIn   = (mode == 2) ? mux_r : drv_r;
    assign greenIn = drv_g;
    assign blueIn  = drv_b;

    task automatic chk(input string tag, input logic [31:0] obs, input int unsigned exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // k = clk edges since reset release; position after tick t is t mod FRAME, outputs describe t-1
    task automatic model_edge();
        int unsigned t, pos, p, ph, pv;
        bit act;
        t = k / 2;
        exp_clk = k % 2;
        pos = t % FRAME;
        exp_x = pos % HT;
        exp_y = pos / HT;
        exp_sof = 0;
        if (k % 2 == 0) begin
            p  = (t - 1) % FRAME;
            ph = p % HT;
            pv = p / HT;
            act = (ph < HA) && (pv < VA);
            exp_r = act ? ((mode == 2) ? (ph % 256) : 32'(drv_r)) : 0;
            exp_g = act ? 32'(drv_g) : 0;
            exp_b = act ? 32'(drv_b) : 0;
            exp_blank = act ? 1 : 0;
            exp_hs = (ph >= HA + HF && ph < HA + HF + HSW) ? 0 : 1;
            exp_vs = (pv >= VA + VF && pv < VA + VF + VSW) ? 0 : 1;
            exp_sof = (p == FRAME - 1) ? 1 : 0;
        end
    endtask

    task automatic check_all();
        chk("pixelX", 32'(pixelX), exp_x);
        chk("pixelY", 32'(pixelY), exp_y);
        chk("red", 32'(oVGA_R), exp_r);
        chk("green", 32'(oVGA_G), exp_g);
        chk("blue", 32'(oVGA_B), exp_b);
        chk("blank_n", 32'(oVGA_BLANK_N), exp_blank);
        chk("hsync", 32'(oVGA_HS), exp_hs);
        chk("vsync", 32'(oVGA_VS), exp_vs);
        chk("start_of_frame", 32'(startOfFrame), exp_sof);
        chk("vga_clk", 32'(oVGA_CLK), exp_clk);
        chk("sync_n", 32'(oVGA_SYNC_N), 1);
    endtask

    // Pulse widths and periods measured in clk cycles
    task automatic track();
        hs_gap++;
        vs_run = oVGA_VS ? vs_run : vs_run + 1;
        if (oVGA_VS && vs_run != 0) begin
            chk("vsync_width", vs_run, 2 * VSW * HT);
            vs_run = 0;
        end
        if (!oVGA_HS) hs_run++;
        else if (hs_run != 0) begin
            chk("hsync_width", hs_run, 2 * HSW);
            hs_run = 0;
        end
        if (hs_prev && !oVGA_HS) begin
            if (hs_seen) chk("line_period", hs_gap, 2 * HT);
            hs_seen = 1;
            hs_gap = 0;
        end
        hs_prev = oVGA_HS;
        sof_gap++;
        if (startOfFrame) begin
            if (sof_seen) chk("frame_period", sof_gap, 2 * FRAME);
            sof_seen = 1;
            sof_gap = 0;
            sof_count++;
        end
    endtask

    task automatic drive_inputs();
        if (mode == 1) begin
            drv_r = 8'hFF; drv_g = 8'hFF; drv_b = 8'hFF;
        end else begin
            drv_r = 8'($urandom); drv_g = 8'($urandom); drv_b = 8'($urandom);
        end
    endtask

    task automatic run_cycle();
        @(posedge clk);
        if (resetN) begin
            k++;
            model_edge();
        end
        @(negedge clk);
        check_all();
        track();
        drive_inputs();
    endtask

    // Entered at a negedge; checks the asynchronous effect, holds, then releases at a negedge
    task automatic apply_reset(input int unsigned cycles);
        resetN = 1'b0;
        k = 0;
        exp_x = 0; exp_y = 0; exp_r = 0; exp_g = 0; exp_b = 0;
        exp_blank = 0; exp_hs = 1; exp_vs = 1; exp_sof = 0; exp_clk = 0;
        hs_run = 0; hs_gap = 0; vs_run = 0; sof_gap = 0; sof_count = 0;
        hs_prev = 1; hs_seen = 0; sof_seen = 0;
        #1;
        check_all();
        repeat (cycles) run_cycle();
        resetN = 1'b1;
    endtask

    initial begin
        n_assert = 0; n_fail = 0; k = 0; mode = 1;
        drv_r = 8'hFF; drv_g = 8'hFF; drv_b = 8'hFF;
        resetN = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // Reset with all-ones colour inputs
        apply_reset(4);

        // Random colour over two frames
        mode = 0;
        repeat (4 * FRAME) run_cycle();

        // Constant white: blanking must zero the colour outside the active area
        mode = 1;
        repeat (2 * FRAME + 8) run_cycle();

        // Colour follows pixelX through the registered mux
        mode = 2;
        repeat (2 * FRAME + 8) run_cycle();

        // Reset in the middle of both sync pulses
        mode = 0;
        found = 0;
        for (int i = 0; i < 4 * FRAME && !found; i++) begin
            run_cycle();
            if (exp_x == HA + HF + 2 && exp_y == VA + VF) found = 1;
        end
        n_assert++;
        assert (found) else begin
            n_fail++;
            $error("FAIL find_sync_point observed=%0d expected=%0d", found, 1);
        end
        chk("vsync_before_reset", 32'(oVGA_VS), 0);
        chk("hsync_before_reset", 32'(oVGA_HS), 0);
        apply_reset(3);

        // Two clean frames after the abort
        repeat (4 * FRAME + 4) run_cycle();
        chk("sof_count", sof_count, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
